// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - state encoding, opcode constants and control word for the multicycle MIPS control FSM
package mips_ctrl_pkg;

  localparam int OPCODE_W = 6;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_MEMWB  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW)   || (op == OP_BEQ) ||
           (op == OP_BNE)   || (op == OP_J)   || (op == OP_ADDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control/status bundle between the control FSM (master) and the datapath (slave)
interface multicycle_control_fsm_if
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_W
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic                    mem_ready;
  logic                    PCWrite;
  logic                    PCWriteCond;
  logic                    pc_en;
  logic                    IorD;
  logic                    MemRead;
  logic                    MemWrite;
  logic                    IRWrite;
  logic                    MemtoReg;
  logic                    RegDst;
  logic                    RegWrite;
  logic                    ALUSrcA;
  logic [1:0]              ALUSrcB;
  logic [1:0]              ALUOp;
  logic [1:0]              PCSource;
  logic                    illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, pc_en, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op
  );

endinterface

// File: rtl/multicycle_control_fsm_decoder.sv
// rtl/multicycle_control_fsm_decoder.sv - ctrl_output_decoder: state plus mem_ready/zero/opcode to datapath control word
module ctrl_output_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t              state,
  input  logic                mem_ready,
  input  logic                zero,
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl
);

  logic branch_taken;

  always_comb begin
    ctrl         = '0;
    branch_taken = zero ^ (opcode == OP_BNE);
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SL2;
        ctrl.illegal_op = !op_legal(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
    // Branch qualification lives here so the PC register sees a single enable.
    ctrl.pc_en = ctrl.pc_write | (ctrl.pc_write_cond & branch_taken);
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle MIPS control FSM top; CTRL_PERF_CNT_EN adds cycle/instruction counters
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
`ifdef CTRL_PERF_CNT_EN
#(
  parameter int CNT_WIDTH = 32
)
`endif
(
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_fsm_if.master    bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]        cycle_cnt,
  output logic [CNT_WIDTH-1:0]        instr_cnt
`endif
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_RESET;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RESET:  next_state = S_FETCH;
      S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:        next_state = S_EXEC;
          OP_LW, OP_SW:    next_state = S_MEMADR;
          OP_BEQ, OP_BNE:  next_state = S_BRANCH;
          OP_J:            next_state = S_JUMP;
          OP_ADDI, OP_ORI: next_state = S_IEXEC;
          default:         next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) next_state = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) next_state = S_FETCH;
      S_EXEC:   next_state = S_RWB;
      S_IEXEC:  next_state = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      default:  next_state = S_RESET;
    endcase
  end

  ctrl_output_decoder u_decoder (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .zero      (bus.zero),
    .opcode    (bus.opcode),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.pc_en       = ctrl.pc_en;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.illegal_op  = ctrl.illegal_op;

`ifdef CTRL_PERF_CNT_EN
  // An instruction retires on any return to S_FETCH other than the post-reset entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_RESET)
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      if (next_state == S_FETCH && state != S_FETCH && state != S_RESET)
        instr_cnt <= instr_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - bench for multicycle_control_fsm: instruction-level reference model plus directed checks
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       pc_en;
    logic       iord;
    logic       memrd;
    logic       memwr;
    logic       irw;
    logic       m2r;
    logic       regdst;
    logic       regwr;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       ill;
  } cw_t;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_ORI  = 6'b001101;

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_J = 4, C_I = 5, C_ILL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  multicycle_control_fsm dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic        m_in_reset = 1'b1;
  int          m_phase    = 0;
  logic [5:0]  m_op       = '0;
  logic [31:0] m_cyc      = '0;
  logic [31:0] m_instr    = '0;

  cw_t dut_w;
  cw_t exp_w;

  assign dut_w = {bus.PCWrite, bus.PCWriteCond, bus.pc_en, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.illegal_op};

  function automatic int cls(input logic [5:0] op);
    case (op)
      T_R:            return C_R;
      T_LW:           return C_LW;
      T_SW:           return C_SW;
      T_BEQ, T_BNE:   return C_BR;
      T_J:            return C_J;
      T_ADDI, T_ORI:  return C_I;
      default:        return C_ILL;
    endcase
  endfunction

  // Expected control word for a given cycle (phase) inside one instruction.
  function automatic cw_t exp_word(input int ph, input logic [5:0] op, input logic mr, input logic z);
    cw_t w;
    int  c;
    w = '0;
    c = cls(op);
    if (ph == 0) begin
      w.memrd = 1'b1; w.srcb = 2'b01; w.irw = mr; w.pcw = mr; w.pc_en = mr;
    end else if (ph == 1) begin
      w.srcb = 2'b11; w.ill = (c == C_ILL);
    end else if (ph == 2) begin
      if (c == C_R) begin
        w.srca = 1'b1; w.aluop = 2'b10;
      end else if (c == C_LW || c == C_SW) begin
        w.srca = 1'b1; w.srcb = 2'b10;
      end else if (c == C_BR) begin
        w.srca = 1'b1; w.aluop = 2'b01; w.pcwc = 1'b1; w.pcsrc = 2'b01;
        w.pc_en = (op == T_BEQ) ? z : !z;
      end else if (c == C_J) begin
        w.pcw = 1'b1; w.pc_en = 1'b1; w.pcsrc = 2'b10;
      end else if (c == C_I) begin
        w.srca = 1'b1; w.srcb = 2'b10; w.aluop = (op == T_ORI) ? 2'b11 : 2'b00;
      end
    end else if (ph == 3) begin
      if (c == C_R) begin
        w.regwr = 1'b1; w.regdst = 1'b1;
      end else if (c == C_LW) begin
        w.memrd = 1'b1; w.iord = 1'b1;
      end else if (c == C_SW) begin
        w.memwr = 1'b1; w.iord = 1'b1;
      end else if (c == C_I) begin
        w.regwr = 1'b1;
      end
    end else if (ph == 4) begin
      w.regwr = 1'b1; w.m2r = 1'b1;
    end
    return w;
  endfunction

  always_comb begin
    exp_w = '0;
    if (rst_n && !m_in_reset)
      exp_w = exp_word(m_phase, (m_phase == 1) ? bus.opcode : m_op, bus.mem_ready, bus.zero);
  end

  // Instruction-level model: phase counts cycles within the current instruction.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_in_reset <= 1'b1; m_phase <= 0; m_cyc <= '0; m_instr <= '0;
    end else if (m_in_reset) begin
      m_in_reset <= 1'b0;
    end else begin
      m_cyc <= m_cyc + 32'd1;
      case (m_phase)
        0: if (bus.mem_ready) m_phase <= 1;
        1: begin
          m_op <= bus.opcode;
          if (cls(bus.opcode) == C_ILL) begin m_phase <= 0; m_instr <= m_instr + 32'd1; end
          else m_phase <= 2;
        end
        2: if (cls(m_op) == C_BR || cls(m_op) == C_J) begin m_phase <= 0; m_instr <= m_instr + 32'd1; end
           else m_phase <= 3;
        3: if (cls(m_op) == C_LW) begin
             if (bus.mem_ready) m_phase <= 4;
           end else if (cls(m_op) != C_SW || bus.mem_ready) begin
             m_phase <= 0; m_instr <= m_instr + 32'd1;
           end
        default: begin m_phase <= 0; m_instr <= m_instr + 32'd1; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (dut_w !== exp_w) begin
        n_fail++;
        $display("FAIL model_cw t=%0t phase=%0d: got %h want %h", $time, m_phase, dut_w, exp_w);
      end
`ifdef CTRL_PERF_CNT_EN
      n_tests++;
      if (cycle_cnt !== m_cyc || instr_cnt !== m_instr) begin
        n_fail++;
        $display("FAIL model_cnt t=%0t: got cyc=%0d instr=%0d want cyc=%0d instr=%0d",
                 $time, cycle_cnt, instr_cnt, m_cyc, m_instr);
      end
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // One clock: apply inputs just after the edge, sample outputs mid-cycle.
  task automatic cyc(input logic mr, input logic z, input logic [5:0] op, output cw_t w);
    bus.mem_ready = mr;
    bus.zero      = z;
    if (m_phase == 0 || m_in_reset) bus.opcode = op;
    #3;
    w = dut_w;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] br_op [3] = '{T_BEQ, T_BNE, T_BNE};
  logic       br_z  [3] = '{1'b1, 1'b1, 1'b0};
  logic       br_en [3] = '{1'b1, 1'b0, 1'b1};
  logic [5:0] pool  [8] = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI, T_ORI};

  initial begin
    cw_t        w;
    logic [4:0] pat5;
    logic [7:0] pat8;
    logic [5:0] op;

    bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.opcode = '0;
    rst_n = 1'b0; chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, T_LW, w);
    check("reset_held_zero", w, 32'd0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, T_LW, w);
    check("reset_state_zero", w, 32'd0);

    pat5 = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, T_LW, w);
      pat5[i] = w.regwr & w.m2r;
    end
    check("lw_wb_only_cycle5", pat5, 5'b10000);
    cyc(1'b0, 1'b0, T_R, w);
    check("lw_back_fetch", {w.memrd, w.iord}, 2'b10);

    pat8 = '0;
    for (int i = 0; i < 4; i++) begin
      cyc((i == 3), 1'b0, T_R, w);
      pat8[2*i +: 2] = {w.irw, w.pcw};
    end
    check("fetch_stall_irw_pcw", pat8, 8'b11_00_00_00);
    repeat (3) cyc(1'b1, 1'b0, T_R, w);

    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, br_z[k], br_op[k], w);
      cyc(1'b1, br_z[k], br_op[k], w);
      cyc(1'b1, br_z[k], br_op[k], w);
      check($sformatf("branch%0d_pc_en", k), {w.pcwc, w.pc_en}, {1'b1, br_en[k]});
    end

    cyc(1'b1, 1'b0, 6'b111111, w);
    cyc(1'b1, 1'b0, 6'b111111, w);
    check("illegal_decode", {w.ill, w.regwr, w.memwr}, 3'b100);
    cyc(1'b0, 1'b0, T_R, w);
    check("illegal_then_fetch", {w.ill, w.memrd, w.iord}, 3'b010);

    rst_n = 1'b0;
    cyc(1'b1, 1'b0, T_R, w);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, T_R, w);
    repeat (4) cyc(1'b1, 1'b0, T_R, w);
    repeat (3) cyc(1'b1, 1'b0, T_J, w);
    repeat (4) cyc(1'b1, 1'b0, T_SW, w);
`ifdef CTRL_PERF_CNT_EN
    check("perf_instr_cnt", instr_cnt, 32'd3);
    check("perf_cycle_cnt", cycle_cnt, 32'd11);
`endif

    repeat (3) cyc(1'b1, 1'b0, T_SW, w);
    bus.mem_ready = 1'b0;
    #1;
    check("memwr_active", bus.MemWrite, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_all_zero", dut_w, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, T_R, w);
    check("post_reset_s_reset", w, 32'd0);
    cyc(1'b0, 1'b0, T_R, w);
    check("post_reset_fetch", {w.memrd, w.memwr, w.iord}, 3'b100);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        repeat (2) cyc(1'b1, 1'b0, T_R, w);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 9) < 8) op = pool[$urandom_range(0, 7)];
      else                          op = 6'($urandom);
      cyc(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), op, w);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
